// File: rtl/nes_alu.sv
// 8-bit 6502-style ALU: operand prep, op decode and flag generation feed one
// register stage that holds result, status and the done strobe.
module nes_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       func,
    input  logic [WIDTH-1:0] status_in,
    input  logic             carry_in,
    input  logic             invert,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] dout,
    output logic             wout,
    output logic [WIDTH-1:0] status_out
);
    localparam int FC = 0, FZ = 1, FV = 6, FN = 7;

    localparam logic [7:0] OP_ADD = 8'h01, OP_AND = 8'h02, OP_OR  = 8'h03,
                           OP_XOR = 8'h04, OP_ASL = 8'h05, OP_LSR = 8'h06,
                           OP_ROL = 8'h07, OP_ROR = 8'h08, OP_INC = 8'h09,
                           OP_DEC = 8'h0A, OP_PAS = 8'h0B, OP_BIT = 8'h0C,
                           OP_CMP = 8'h0D;

    logic [WIDTH-1:0] bp, r, s;
    logic [WIDTH:0]   sum;
    logic             valid;

    always_comb begin
        bp    = invert ? ~b_in : b_in;
        r     = '0;
        s     = status_in;
        sum   = '0;
        valid = 1'b1;
        case (func)
            OP_ADD: begin
                sum   = {1'b0, a_in} + {1'b0, bp} + {{WIDTH{1'b0}}, carry_in};
                r     = sum[WIDTH-1:0];
                s[FC] = sum[WIDTH];
                s[FV] = (a_in[7] == bp[7]) && (r[7] != a_in[7]);
            end
            OP_AND: r = a_in & bp;
            OP_OR:  r = a_in | bp;
            OP_XOR: r = a_in ^ bp;
            OP_ASL: begin r = {a_in[6:0], 1'b0};     s[FC] = a_in[7]; end
            OP_LSR: begin r = {1'b0, a_in[7:1]};     s[FC] = a_in[0]; end
            OP_ROL: begin r = {a_in[6:0], carry_in}; s[FC] = a_in[7]; end
            OP_ROR: begin r = {carry_in, a_in[7:1]}; s[FC] = a_in[0]; end
            OP_INC: r = a_in + 8'd1;
            OP_DEC: r = a_in - 8'd1;
            OP_PAS: r = a_in;
            OP_BIT: begin
                r     = a_in & b_in;
                s[FV] = b_in[6];
            end
            // CMP always subtracts the raw operand; invert does not apply
            OP_CMP: begin
                sum   = {1'b0, a_in} + {1'b0, ~b_in} + {{WIDTH{1'b0}}, 1'b1};
                r     = sum[WIDTH-1:0];
                s[FC] = sum[WIDTH];
            end
            default: valid = 1'b0;
        endcase
        s[FZ] = (r == '0);
        s[FN] = (func == OP_BIT) ? b_in[7] : r[7];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            status_out <= '0;
            wout       <= 1'b0;
        end else begin
            wout <= valid;
            if (valid) begin
                dout       <= r;
                status_out <= s;
            end
        end
    end
endmodule

// File: tb/tb_nes_alu.sv
// Scoreboard bench for nes_alu: directed plan vectors with hand-computed
// expectations, then randomized ops checked against a behavioural model.
module tb_nes_alu;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] func = 8'h00, status_in = 8'h00, a_in = 8'h00, b_in = 8'h00;
    logic       carry_in = 1'b0, invert = 1'b0;
    logic [7:0] dout, status_out;
    logic       wout;

    nes_alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .func(func), .status_in(status_in),
        .carry_in(carry_in), .invert(invert), .a_in(a_in), .b_in(b_in),
        .dout(dout), .wout(wout), .status_out(status_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic [7:0] s;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0;
    logic [7:0] hd = 8'h00, hs = 8'h00;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // independent reference: integer arithmetic, alternate overflow form
    function automatic logic [16:0] model(input logic [7:0] f, a, b, input logic ci, inv,
                                          input logic [7:0] st);
        logic [7:0] bb, d, s;
        int t;
        logic v;
        bb = inv ? ~b : b;
        s = st; d = 8'h00; v = 1'b1;
        case (f)
            8'h01: begin
                t = int'(a) + int'(bb) + int'(ci);
                d = t[7:0];
                s[0] = (t > 255);
                s[6] = (((a ^ d) & (bb ^ d) & 8'h80) != 0);
            end
            8'h02: d = a & bb;
            8'h03: d = a | bb;
            8'h04: d = a ^ bb;
            8'h05: begin d = a << 1; s[0] = a[7]; end
            8'h06: begin d = a >> 1; s[0] = a[0]; end
            8'h07: begin d = (a << 1) | {7'd0, ci}; s[0] = a[7]; end
            8'h08: begin d = (a >> 1) | {ci, 7'd0}; s[0] = a[0]; end
            8'h09: begin t = (int'(a) + 1) % 256; d = t[7:0]; end
            8'h0A: begin t = (int'(a) + 255) % 256; d = t[7:0]; end
            8'h0B: d = a;
            8'h0C: d = a & b;
            8'h0D: begin t = int'(a) - int'(b); d = t[7:0]; s[0] = (a >= b); end
            default: v = 1'b0;
        endcase
        s[1] = (d == 8'h00);
        s[7] = (f == 8'h0C) ? b[7] : d[7];
        if (f == 8'h0C) s[6] = b[6];
        return {v, d, s};
    endfunction

    task automatic drive(input logic [7:0] f, a, b, input logic ci, inv,
                         input logic [7:0] st, ed, es);
        exp_t e;
        @(negedge clk);
        func = f; a_in = a; b_in = b; carry_in = ci; invert = inv; status_in = st;
        e.w = (f >= 8'h01 && f <= 8'h0D);
        if (e.w) begin hd = ed; hs = es; end
        e.d = hd; e.s = hs;
        q.push_back(e);
    endtask

    task automatic drive_rand();
        logic [7:0] f, a, b, st;
        logic ci, inv;
        logic [16:0] m;
        f   = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 14));
        a   = 8'($urandom); b = 8'($urandom); st = 8'($urandom);
        ci  = 1'($urandom); inv = 1'($urandom);
        m   = model(f, a, b, ci, inv, st);
        drive(f, a, b, ci, inv, st, m[15:8], m[7:0]);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("wout", {7'd0, wout}, {7'd0, e.w});
            chk("dout", dout, e.d);
            chk("status", status_out, e.s);
        end
    end

    initial begin
        #3;
        chk("rst_dout", dout, 8'h00);
        chk("rst_stat", status_out, 8'h00);
        chk("rst_wout", {7'd0, wout}, 8'h00);
        repeat (2) @(posedge clk);
        #1 chk("rst_hold", dout, 8'h00);
        @(negedge clk) reset = 1'b0;

        drive(8'h01, 8'h50, 8'h50, 1'b0, 1'b0, 8'h00, 8'hA0, 8'hC0); // ADD overflow
        drive(8'h01, 8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 8'h00, 8'h03); // SBC via invert
        drive(8'h07, 8'h80, 8'h00, 1'b1, 1'b0, 8'h00, 8'h01, 8'h01); // ROL
        drive(8'h08, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00, 8'h80, 8'h81); // ROR
        drive(8'h0D, 8'h10, 8'h20, 1'b0, 1'b0, 8'h0C, 8'hF0, 8'h8C); // CMP less
        drive(8'h0D, 8'h33, 8'h33, 1'b0, 1'b1, 8'h0C, 8'h00, 8'h0F); // CMP equal, invert ignored
        drive(8'h0C, 8'h0F, 8'hC0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC2); // BIT
        drive(8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'hFF, 8'h81); // DEC wrap, C kept
        drive(8'h09, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 8'h42); // INC wrap, V kept
        drive(8'h06, 8'h81, 8'h00, 1'b1, 1'b0, 8'h80, 8'h40, 8'h01); // LSR clears N
        drive(8'h00, 8'h12, 8'h34, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00); // NOP holds
        drive(8'hFF, 8'h12, 8'h34, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00); // invalid holds
        drive(8'h05, 8'hC1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h82, 8'h81); // ASL

        repeat (40) drive_rand();

        // reset in the middle of an ADD: pending result is dropped
        drive(8'h01, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h80, 8'hC0);
        drive(8'h01, 8'h10, 8'h01, 1'b0, 1'b0, 8'h00, 8'h11, 8'h00);
        #2 reset = 1'b1;
        q.delete();
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_stat", status_out, 8'h00);
        chk("arst_wout", {7'd0, wout}, 8'h00);
        @(posedge clk); #1;
        chk("arst_hold_d", dout, 8'h00);
        chk("arst_hold_w", {7'd0, wout}, 8'h00);
        hd = 8'h00; hs = 8'h00;
        @(negedge clk) reset = 1'b0;
        drive(8'h0B, 8'h80, 8'h00, 1'b0, 1'b0, 8'h10, 8'h80, 8'h90); // first op after reset
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nes_alu.md
Name: nes_alu

Overview:
8-bit 6502-style arithmetic/logic unit for the NES CPU core. The decoder drives it with an operation code, and the data bus supplies operands A and B. It returns a registered result, an updated status byte and a one-cycle done strobe. The top level writes the status byte into STAT whenever the decoder's update-status line is set.

Parameters:
WIDTH, 8, operand, result and status width (fixed at 8; no other value supported)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
func  input  8  operation code (see Behaviour)
status_in  input  8  current STAT register value
carry_in  input  1  carry into ADD and rotates
invert  input  1  when 1, B is bitwise inverted before the operation (SBC/CMP use)
a_in  input  8  operand A
b_in  input  8  operand B
dout  output  8  registered result
wout  output  1  done strobe, one cycle
status_out  output  8  registered status

Behaviour:
- Status bit map: C=0, Z=1, I=2, D=3, B=4, bit5 unused, V=6, N=7.
- Operand prep: b' = invert ? ~b_in : b_in. b' replaces B in every operation.
- func codes:
  - 00 NOP
  - 01 ADD: r = A + b' + carry_in
  - 02 AND: A & b'
  - 03 OR: A | b'
  - 04 XOR: A ^ b'
  - 05 ASL: A << 1
  - 06 LSR: A >> 1
  - 07 ROL: {A[6:0], carry_in}
  - 08 ROR: {carry_in, A[7:1]}
  - 09 INC: A + 1
  - 0A DEC: A - 1
  - 0B PASS: A
  - 0C BIT
  - 0D CMP: A + ~b_in + 1; the invert input is ignored for CMP
  - All other codes are treated as NOP.
- Flag updates; flags not listed are copied from status_in:
  - ADD: C = carry out of bit 7; V = (A[7]==b'[7]) && (r[7]!=A[7]); Z, N from r.
  - AND/OR/XOR/PASS/INC/DEC: Z, N only. INC/DEC wrap 8'hFF<->8'h00 with C unchanged.
  - ASL/ROL: C = A[7]. LSR/ROR: C = A[0]. Z, N from r. LSR always gives N=0.
  - BIT: dout = A & b_in; Z = (A & b_in) == 0; N = b_in[7]; V = b_in[6].
  - CMP: dout = 8-bit difference; C = (A >= b_in) unsigned; Z = (A == b_in); N = diff[7]. V is unchanged.
- Decimal mode: the D flag is ignored; arithmetic is always binary.
- Timing:
  - Inputs are sampled on each rising clk edge.
  - For a valid non-NOP func, dout and status_out load the computed values at that edge, and wout = 1 for the following cycle. Latency is one cycle.
  - If the func is held valid, the ALU recomputes every cycle with current inputs and wout stays high.
  - On NOP or an invalid code, dout and status_out hold their values and wout = 0.
- Combinational path: there is none from inputs to outputs; all three outputs are registers.
- Reset: asynchronous. dout = 8'h00, status_out = 8'h00, wout = 0 immediately, and outputs stay there while reset is high. Reset asserted mid-operation discards the pending result. The first valid edge after reset release computes normally.

Test Plan:
- ADD: A=8'h50, B=8'h50, carry_in=0, invert=0 -> dout=8'hA0, V=1, N=1, C=0, Z=0, wout=1 for one cycle.
- SBC via invert: A=8'h05, B=8'h05, invert=1, carry_in=1 -> dout=8'h00, Z=1, C=1, N=0, V=0.
- Rotates, with status_in=8'h00 and carry_in=1:
  - ROL with A=8'h80 -> dout=8'h01, C=1.
  - ROR with A=8'h01 -> dout=8'h80, C=1, N=1.
- CMP: A=8'h10, B=8'h20 -> C=0, Z=0, N=1. Then A=B=8'h33 -> C=1, Z=1. I/D/B bits are passed from status_in=8'h0C unchanged.
- BIT and passthrough: A=8'h0F, B=8'hC0 -> Z=1, N=1, V=1. DEC with A=8'h00 -> dout=8'hFF, N=1, C unchanged.
- Control: func=00 or 8'hFF leaves outputs held with wout=0. Asserting reset mid-ADD clears dout, status_out and wout asynchronously.
